// File: rtl/shot_clock_monitor.sv
// Shot-clock consumer: syncs and deglitches the ripple-counter bus, drives BCD digits,
// the expiry buzzer and the final-seconds blink blanking.
module shot_clock_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int BUZZ_CYCLES   = 50000000,
  parameter int WARN_LEVEL    = 5,
  parameter int BLINK_CYCLES  = 12500000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [4:0] cronometro,
  input  logic       chaveParar,
  output logic [3:0] digit_tens,
  output logic [3:0] digit_ones,
  output logic       blank,
  output logic       buzzer,
  output logic       expired,
  output logic       range_err
);

  localparam int SW  = $clog2(STABLE_CYCLES + 1);
  localparam int BZW = (BUZZ_CYCLES > 1) ? $clog2(BUZZ_CYCLES) : 1;
  localparam int BLW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] BUZZ = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  logic [4:0]     cronoS1, cronoS2, cronoPrev, val;
  logic           stopS1, stopS2;
  logic [SW-1:0]  stableCnt, stableNext;
  logic [1:0]     state;
  logic [BZW-1:0] buzzCnt;
  logic [BLW-1:0] blinkCnt;
  logic           valNz, inWarn;

  // A new value counts as its own first sample; acceptance happens on the STABLE_CYCLES-th.
  always_comb begin
    stableNext = stableCnt;
    if (cronoS2 != cronoPrev)
      stableNext = SW'(1);
    else if (stableCnt != SW'(STABLE_CYCLES))
      stableNext = stableCnt + SW'(1);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cronoS1   <= '0;
      cronoS2   <= '0;
      cronoPrev <= '0;
      stopS1    <= 1'b0;
      stopS2    <= 1'b0;
      stableCnt <= '0;
      val       <= '0;
    end else begin
      cronoS1   <= cronometro;
      cronoS2   <= cronoS1;
      stopS1    <= chaveParar;
      stopS2    <= stopS1;
      cronoPrev <= cronoS2;
      stableCnt <= stableNext;
      if (stableNext == SW'(STABLE_CYCLES))
        val <= cronoS2;
    end
  end

  assign valNz  = (val != 5'd0);
  assign inWarn = (state == RUN) && valNz && (val <= 5'(WARN_LEVEL));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      digit_tens <= '0;
      digit_ones <= '0;
      range_err  <= 1'b0;
    end else if (val > 5'd24) begin
      digit_tens <= 4'hF;
      digit_ones <= 4'hF;
      range_err  <= 1'b1;
    end else if (val >= 5'd20) begin
      digit_tens <= 4'd2;
      digit_ones <= 4'(val - 5'd20);
      range_err  <= 1'b0;
    end else if (val >= 5'd10) begin
      digit_tens <= 4'd1;
      digit_ones <= 4'(val - 5'd10);
      range_err  <= 1'b0;
    end else begin
      digit_tens <= 4'd0;
      digit_ones <= 4'(val);
      range_err  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= IDLE;
      buzzCnt <= '0;
    end else begin
      if (state != BUZZ) buzzCnt <= '0;
      case (state)
        IDLE: if (valNz) state <= RUN;
        RUN:  if (!valNz) state <= stopS2 ? IDLE : BUZZ;
        BUZZ: begin
          // Reload beats timeout when both land in the same cycle.
          if (valNz) begin
            state   <= RUN;
            buzzCnt <= '0;
          end else if (buzzCnt == BZW'(BUZZ_CYCLES - 1)) begin
            state   <= HOLD;
            buzzCnt <= '0;
          end else begin
            buzzCnt <= buzzCnt + BZW'(1);
          end
        end
        HOLD: if (valNz) state <= RUN;
        default: state <= IDLE;
      endcase
    end
  end

  assign buzzer  = (state == BUZZ);
  assign expired = (state == BUZZ) || (state == HOLD);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      blinkCnt <= '0;
      blank    <= 1'b0;
    end else if (!inWarn) begin
      blinkCnt <= '0;
      blank    <= 1'b0;
    end else if (blinkCnt == BLW'(BLINK_CYCLES - 1)) begin
      blinkCnt <= '0;
      blank    <= ~blank;
    end else begin
      blinkCnt <= blinkCnt + BLW'(1);
    end
  end

endmodule

// File: tb/tb_shot_clock_monitor.sv
// Directed bench for shot_clock_monitor with short timing parameters.
module tb_shot_clock_monitor;

  logic       clk = 1'b0;
  logic       clr;
  logic [4:0] cronometro;
  logic       chaveParar;
  logic [3:0] digit_tens, digit_ones;
  logic       blank, buzzer, expired, range_err;

  logic [11:0] outs;
  logic [7:0]  digits;
  int checks = 0;
  int failures = 0;
  logic flag;

  assign outs   = {digit_tens, digit_ones, blank, buzzer, expired, range_err};
  assign digits = {digit_tens, digit_ones};

  shot_clock_monitor #(
    .STABLE_CYCLES(3),
    .BUZZ_CYCLES  (8),
    .WARN_LEVEL   (5),
    .BLINK_CYCLES (4)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .cronometro(cronometro),
    .chaveParar(chaveParar),
    .digit_tens(digit_tens),
    .digit_ones(digit_ones),
    .blank     (blank),
    .buzzer    (buzzer),
    .expired   (expired),
    .range_err (range_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and land 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  initial begin
    clr = 1'b1; cronometro = 5'd24; chaveParar = 1'b0;
    tick(3);
    chk("rst_outs", outs, 12'h000);
    clr = 1'b0;
    tick(5); chk("rst_lat5", digits, 8'h00);
    tick(1); chk("rst_lat6", digits, 8'h24);
    chk("rst_blank", blank, 1'b0);
    chk("rst_buzz", buzzer, 1'b0);

    // glitch rejection
    cronometro = 5'd8; tick(8); chk("glitch_pre", digits, 8'h08);
    cronometro = 5'd15; tick(2); cronometro = 5'd7;
    flag = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (digits == 8'h15) flag = 1'b1;
    end
    chk("glitch_rej", flag, 1'b0);
    chk("glitch_settle", digits, 8'h07);

    // expiry
    cronometro = 5'd3; tick(8);
    cronometro = 5'd2; tick(8);
    cronometro = 5'd1; tick(8); chk("exp_one", digits, 8'h01);
    cronometro = 5'd0; tick(5); chk("exp_pre", buzzer, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick(1); chk("exp_buzz", buzzer, 1'b1);
    end
    tick(1);
    chk("exp_buzz_end", buzzer, 1'b0);
    chk("exp_expired", expired, 1'b1);
    tick(4); chk("exp_hold", {buzzer, expired}, 2'b01);
    cronometro = 5'd24;
    tick(5); chk("exp_reload_pre", expired, 1'b1);
    tick(1); chk("exp_reload", expired, 1'b0);
    chk("exp_reload_dig", digits, 8'h24);

    // stop key at zero
    chaveParar = 1'b1; cronometro = 5'd0;
    flag = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (buzzer || expired) flag = 1'b1;
    end
    chk("stop_nobuzz", flag, 1'b0);
    chk("stop_dig", digits, 8'h00);
    chaveParar = 1'b0;
    flag = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (buzzer || expired) flag = 1'b1;
    end
    chk("idle_nobuzz", flag, 1'b0);

    // blink window
    cronometro = 5'd6; tick(8);
    chk("blink_six_dig", digits, 8'h06);
    chk("blink_six", blank, 1'b0);
    cronometro = 5'd4; tick(4);
    for (int k = 5; k <= 20; k++) begin
      tick(1); chk("blink", blank, ((k - 5) / 4) % 2);
    end
    cronometro = 5'd6; tick(6); chk("blink_exit", blank, 1'b0);

    // reload aborts the buzz on its third cycle
    cronometro = 5'd0; tick(3);
    cronometro = 5'd14; tick(3);
    chk("abort_b1", buzzer, 1'b1);
    tick(1); chk("abort_b2", buzzer, 1'b1);
    tick(1); chk("abort_b3", {buzzer, expired}, 2'b11);
    tick(1); chk("abort_drop", {buzzer, expired}, 2'b00);
    chk("abort_dig", digits, 8'h14);

    // out of range
    cronometro = 5'd27;
    tick(5); chk("range_pre", range_err, 1'b0);
    tick(1); chk("range_err", range_err, 1'b1);
    chk("range_dig", digits, 8'hFF);

    // reset mid-buzz
    cronometro = 5'd0; tick(8);
    chk("mid_buzz", {buzzer, expired, range_err}, 3'b110);
    #1 clr = 1'b1;
    #1 chk("clr_async", outs, 12'h000);
    tick(2); chk("clr_hold", outs, 12'h000);
    clr = 1'b0;
    tick(10); chk("post_clr", {buzzer, expired}, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shot_clock_monitor.md
Name: shot_clock_monitor

Overview:
- Consumer end of the 5-bit shot-clock countdown bus (cronometro) produced by the ripple-counter timer.
- Synchronises and deglitches the bus into the system clock domain and converts it to two BCD display digits.
- Detects expiry and drives the buzzer for a fixed time; blanks the display in a blink pattern during the final seconds.
- Sits between the countdown timer and the 7-segment/buzzer outputs of the scoreboard.

Parameters:
- STABLE_CYCLES, 4: consecutive identical synchronised samples required before the bus value is accepted.
- BUZZ_CYCLES, 50000000: buzzer on-time in clk cycles (1 s at 50 MHz).
- WARN_LEVEL, 5: blinking is active while the accepted value is in 1..WARN_LEVEL.
- BLINK_CYCLES, 12500000: clk cycles per blink half-period.

Ports:
- clk  input  1  system clock.
- clr  input  1  reset, asynchronous, active-high.
- cronometro  input  5  countdown value from timer; asynchronous to clk; may glitch during ripple.
- chaveParar  input  1  stop key level; asynchronous to clk.
- digit_tens  output  4  BCD tens digit of accepted value.
- digit_ones  output  4  BCD ones digit of accepted value.
- blank  output  1  1 = display off (blink off-phase).
- buzzer  output  1  1 = buzzer on.
- expired  output  1  1 = shot clock has expired and has not yet been reloaded.
- range_err  output  1  1 = accepted value is above 24.

Behaviour:
- Reset (clr=1, any time, including mid-buzz):
  - All state is cleared immediately; FSM returns to IDLE.
  - Accepted value val=0.
  - Outputs: digit_tens=0, digit_ones=0, blank=0, buzzer=0, expired=0, range_err=0.
- Synchronisers:
  - cronometro and chaveParar each pass through a 2-flop synchroniser.
  - The stability counter restarts whenever the synchronised bus differs from the previous sample.
  - val is loaded once STABLE_CYCLES consecutive equal samples have been seen.
  - Latency from a settled bus change to the new val: 2 + STABLE_CYCLES cycles.
- Digits (registered, 1 cycle after val):
  - tens = 2 if val>=20, 1 if val>=10, else 0; ones = val - 10*tens.
  - If val>24: both digits = 4'hF and range_err=1; FSM treats the value as nonzero.
- FSM states:
  - IDLE: val==0 and not armed. Goes to RUN when val!=0.
  - RUN: goes to BUZZ when val becomes 0 and the synchronised stop key is 0. If val becomes 0 while the stop key is 1, goes to IDLE with no buzz.
  - BUZZ: buzzer=1, expired=1, buzz counter increments each cycle.
    - After BUZZ_CYCLES cycles in BUZZ, goes to HOLD.
    - If val becomes nonzero (reload) first, goes to RUN; buzzer and expired drop on the next cycle.
  - HOLD: buzzer=0, expired=1. Goes to RUN when val!=0, clearing expired.
- Transition timing: buzzer rises on the first clk edge after val is accepted as 0; it stays high for exactly BUZZ_CYCLES cycles unless a reload aborts it.
- Blink:
  - Active only in RUN with val in 1..WARN_LEVEL.
  - Blink counter wraps at BLINK_CYCLES-1 and toggles blank each wrap. The first half-period after entering the window is blank=0.
  - Outside the window: blank=0 and the blink counter is held at 0.
- Simultaneous events:
  - val going 0 in the same cycle the stop key rises: the synchronised stop key value in that cycle decides.
  - Reset has priority over everything.

Test Plan (STABLE_CYCLES=3, BUZZ_CYCLES=8, BLINK_CYCLES=4, WARN_LEVEL=5):
- Reset check: after clr pulse, hold cronometro=24 steady → digit_tens=2, digit_ones=4 exactly 6 cycles after clr deasserts; blank=0, buzzer=0.
- Glitch rejection: bus 8→7 with a 2-cycle glitch to 15 in between → digits never show 1/5; they show 0/7 after settling.
- Expiry: count 3,2,1,0 with stop key=0 → buzzer=1 for exactly 8 cycles, then buzzer=0 with expired=1. Then load 24 → expired=0, state RUN.
- Stop at zero: reach val=0 with chaveParar=1 → buzzer stays 0, expired stays 0, FSM in IDLE.
- Blink: hold val=4 in RUN → blank toggles 0,1,0,… every 4 cycles. Set val=6 → blank=0 within 1 cycle after val updates.
- Abort and range: reload to 14 at buzz cycle 3 → buzzer=0 next cycle, digits 1/4. Then drive 27 → range_err=1, digits F/F. Assert clr mid-buzz → all outputs 0.
